// File: rtl/game_frame_controller.sv
// game_frame_controller: raster scan counters plus a frame-synchronous IDLE/PLAY/PAUSED
// game FSM that moves two paddles once per frame from synchronized button inputs.
module game_frame_controller #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int STEP       = 4,
  parameter int POS_MIN    = 50,
  parameter int POS_MAX    = 499,
  parameter int POS_CENTER = 275
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       start,
  input  logic       pause,
  input  logic       t1_up,
  input  logic       t1_down,
  input  logic       t2_up,
  input  logic       t2_down,
  output logic [9:0] current_pixel,
  output logic [9:0] current_line,
  output logic [9:0] team1_ver_pos,
  output logic [9:0] team2_ver_pos,
  output logic       frame_tick,
  output logic [1:0] game_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSED = 2'd2} state_t;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] P_MIN  = 10'(POS_MIN);
  localparam logic [9:0] P_MAX  = 10'(POS_MAX);
  localparam logic [9:0] P_CTR  = 10'(POS_CENTER);
  localparam logic [9:0] P_STEP = 10'(STEP);
  // Thresholds chosen so the step is only applied when it cannot cross a bound.
  localparam logic [9:0] P_LO   = 10'(POS_MIN + STEP);
  localparam logic [9:0] P_HI   = 10'(POS_MAX - STEP);

  logic [5:0] r_meta, r_sync;
  logic [9:0] r_pixel, r_line, r_pos1, r_pos2;
  state_t     r_state, w_state_nx;
  logic       w_start, w_pause, w_pix_last, w_line_last, w_move;

  always_ff @(posedge clk or posedge rst)
    if (rst) {r_meta, r_sync} <= '0;
    else     {r_meta, r_sync} <= {{start, pause, t1_up, t1_down, t2_up, t2_down}, r_meta};

  assign w_start     = r_sync[5];
  assign w_pause     = r_sync[4];
  assign w_pix_last  = r_pixel == H_LAST;
  assign w_line_last = r_line == V_LAST;
  assign frame_tick  = pix_en && w_pix_last && w_line_last;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pixel <= '0;
      r_line  <= '0;
    end else if (pix_en) begin
      r_pixel <= w_pix_last ? '0 : r_pixel + 10'd1;
      if (w_pix_last) r_line <= w_line_last ? '0 : r_line + 10'd1;
    end

  always_comb begin
    w_state_nx = r_state;
    if (frame_tick)
      unique case (r_state)
        IDLE:    w_state_nx = w_start ? PLAY : IDLE;
        PLAY:    w_state_nx = w_pause ? PAUSED : PLAY;
        PAUSED:  w_state_nx = (w_start && !w_pause) ? PLAY : PAUSED;
        default: w_state_nx = IDLE;
      endcase
  end

  // Paddles move on frames that end in PLAY, except the frame that leaves IDLE.
  assign w_move = frame_tick && w_state_nx == PLAY && r_state != IDLE;

  function automatic logic [9:0] step_pos(input logic [9:0] p, input logic up, input logic dn);
    return (up && !dn) ? ((p >= P_LO) ? p - P_STEP : P_MIN) :
           (dn && !up) ? ((p <= P_HI) ? p + P_STEP : P_MAX) : p;
  endfunction

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_pos1  <= P_CTR;
      r_pos2  <= P_CTR;
    end else begin
      r_state <= w_state_nx;
      if (frame_tick && r_state == IDLE) begin
        r_pos1 <= P_CTR;
        r_pos2 <= P_CTR;
      end else if (w_move) begin
        r_pos1 <= step_pos(r_pos1, r_sync[3], r_sync[2]);
        r_pos2 <= step_pos(r_pos2, r_sync[1], r_sync[0]);
      end
    end

  assign current_pixel = r_pixel;
  assign current_line  = r_line;
  assign team1_ver_pos = r_pos1;
  assign team2_ver_pos = r_pos2;
  assign game_state    = r_state;
endmodule
